// File: rtl/ex_ctrl_pkg.sv
// Shared definitions for the EX-stage sequencing controllers: FSM encoding and
// default multi-cycle latency sizing.
package ex_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int MC_MAX_LAT_DEF = 8;
  localparam int CNT_W_DEF      = 4;

endpackage

// File: rtl/ex_sat_cnt.sv
// Saturating up-counter with enable; sticks at all-ones until reset.
// One-cycle update latency, no backpressure.
module ex_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ex2_stage_ctrl.sv
// EX2 sequencing controller: ACT commits EX2->ME2, holds EX2 for multi-cycle ops
// and ME2 stalls; outputs are combinational from state, ME2 stall is the backpressure.
module ex2_stage_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int MC_MAX_LAT = MC_MAX_LAT_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int STC_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             r_ex2_valid_Q,
  input  logic             ex2_mc,
  input  logic [CNT_W-1:0] ex2_mc_lat,
  input  logic             me2_stall,
  input  logic             flush,
  output logic             ACT,
  output logic             BUBBLE,
  output logic             ex2_hold,
  output logic             mc_start,
  output logic             mc_kill,
  output logic [STC_W-1:0] ex2_stall_cnt
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lat_eff;
  logic             act_c, bubble_c, hold_c, start_c, kill_c;

  assign lat_eff = (ex2_mc_lat > CNT_W'(MC_MAX_LAT)) ? CNT_W'(MC_MAX_LAT) : ex2_mc_lat;

  // ME2 takes whatever is presented whenever it is not stalled; BUBBLE alone
  // decides whether that is a real instruction.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_c    = ~me2_stall;
    bubble_c = 1'b1;
    hold_c   = 1'b0;
    start_c  = 1'b0;
    kill_c   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      kill_c  = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (r_ex2_valid_Q) begin
            if (ex2_mc && (lat_eff != '0)) begin
              start_c = 1'b1;
              hold_c  = 1'b1;
              cnt_d   = lat_eff;
              state_d = ST_EXEC;
            end else if (!me2_stall) begin
              bubble_c = 1'b0;
            end else begin
              hold_c = 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d = '0;
            if (!me2_stall) begin
              bubble_c = 1'b0;
              state_d  = ST_IDLE;
            end else begin
              hold_c  = 1'b1;
              state_d = ST_HOLD;
            end
          end else begin
            cnt_d  = cnt_q - CNT_W'(1);
            hold_c = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!me2_stall) begin
            bubble_c = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            hold_c = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  assign ACT      = act_c & RST;
  assign BUBBLE   = bubble_c | ~RST;
  assign ex2_hold = hold_c & RST;
  assign mc_start = start_c & RST;
  assign mc_kill  = kill_c & RST;

  ex_sat_cnt #(.W(STC_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .en    (ex2_hold),
    .cnt   (ex2_stall_cnt)
  );

endmodule

// File: tb/tb_ex2_stage_ctrl.sv
// Bench for ex2_stage_ctrl: directed vector table, async-reset sequence, then
// randomized traffic against a cycle-number based reference model.
module tb_ex2_stage_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        r_ex2_valid_Q, ex2_mc, me2_stall, flush;
  logic [3:0]  ex2_mc_lat;
  logic        ACT, BUBBLE, ex2_hold, mc_start, mc_kill;
  logic [15:0] ex2_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ex2_stage_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .r_ex2_valid_Q (r_ex2_valid_Q),
    .ex2_mc        (ex2_mc),
    .ex2_mc_lat    (ex2_mc_lat),
    .me2_stall     (me2_stall),
    .flush         (flush),
    .ACT           (ACT),
    .BUBBLE        (BUBBLE),
    .ex2_hold      (ex2_hold),
    .mc_start      (mc_start),
    .mc_kill       (mc_kill),
    .ex2_stall_cnt (ex2_stall_cnt)
  );

  // o = {ACT, BUBBLE, ex2_hold, mc_start, mc_kill}; cnt = stall count seen during the cycle
  typedef struct {
    bit         v, mc, st, fl;
    int         lat;
    logic [4:0] o;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, bit mc, int lat, bit st, bit fl, logic [4:0] o, int cnt);
    vec_t r;
    r.v = v; r.mc = mc; r.lat = lat; r.st = st; r.fl = fl; r.o = o; r.cnt = cnt;
    return r;
  endfunction

  task automatic drive(input bit v, input bit mc, input int lat, input bit st, input bit fl);
    r_ex2_valid_Q = v;
    ex2_mc        = mc;
    ex2_mc_lat    = 4'(lat);
    me2_stall     = st;
    flush         = fl;
  endtask

  task automatic chk(input string nm, input logic [4:0] exp_o, input int exp_c);
    logic [4:0] got;
    got = {ACT, BUBBLE, ex2_hold, mc_start, mc_kill};
    checks++;
    if (got !== exp_o) begin
      errors++;
      $display("FAIL %s act/bub/hold/start/kill got %b want %b", nm, got, exp_o);
    end
    checks++;
    if (ex2_stall_cnt !== 16'(exp_c)) begin
      errors++;
      $display("FAIL %s stall_cnt got %0d want %0d", nm, ex2_stall_cnt, exp_c);
    end
  endtask

  // Reference model: tracks the cycle number at which a multi-cycle result is ready.
  bit inflight;
  int ready_at;
  int m_cnt;

  task automatic model(input int now, input bit v, input bit mc, input int lat, input bit st,
                       input bit fl, output logic [4:0] o);
    bit a, b, h, s, k;
    int l;
    a = !st; b = 1; h = 0; s = 0; k = 0;
    l = (lat > 8) ? 8 : lat;
    if (fl) begin
      k = inflight;
      inflight = 0;
    end else if (inflight) begin
      if (now >= ready_at && !st) begin
        b = 0;
        inflight = 0;
      end else begin
        h = 1;
      end
    end else if (v) begin
      if (mc && l > 0) begin
        s = 1; h = 1;
        inflight = 1;
        ready_at = now + l;
      end else if (!st) begin
        b = 0;
      end else begin
        h = 1;
      end
    end
    o = {a, b, h, s, k};
  endtask

  initial begin
    logic [4:0] exp_o;
    int sel;
    bit v, mc, st, fl;
    int lat;

    // single-cycle stream
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1,0,0,0,0, 5'b10000, 0));
    // L=3, no stall
    tbl.push_back(mk(1,1,3,0,0, 5'b11110, 0));
    tbl.push_back(mk(1,1,3,0,0, 5'b11100, 1));
    tbl.push_back(mk(1,1,3,0,0, 5'b11100, 2));
    tbl.push_back(mk(1,1,3,0,0, 5'b10000, 3));
    tbl.push_back(mk(0,0,0,0,0, 5'b11000, 3));
    // L=2, ME2 stalled in cycles 2-3
    tbl.push_back(mk(1,1,2,0,0, 5'b11110, 3));
    tbl.push_back(mk(1,1,2,0,0, 5'b11100, 4));
    tbl.push_back(mk(1,1,2,1,0, 5'b01100, 5));
    tbl.push_back(mk(1,1,2,1,0, 5'b01100, 6));
    tbl.push_back(mk(1,1,2,0,0, 5'b10000, 7));
    // L=5, flush in cycle 2
    tbl.push_back(mk(1,1,5,0,0, 5'b11110, 7));
    tbl.push_back(mk(1,1,5,0,0, 5'b11100, 8));
    tbl.push_back(mk(1,1,5,0,1, 5'b11001, 9));
    tbl.push_back(mk(0,0,0,0,0, 5'b11000, 9));
    // latency 15 saturates to 8
    tbl.push_back(mk(1,1,15,0,0, 5'b11110, 9));
    for (int i = 1; i < 8; i++) tbl.push_back(mk(1,1,15,0,0, 5'b11100, 9 + i));
    tbl.push_back(mk(1,1,15,0,0, 5'b10000, 17));
    // multi-cycle with zero latency acts single-cycle
    tbl.push_back(mk(1,1,0,0,0, 5'b10000, 17));
    tbl.push_back(mk(1,1,0,1,0, 5'b01100, 17));
    tbl.push_back(mk(1,1,0,0,0, 5'b10000, 18));
    tbl.push_back(mk(0,0,0,1,0, 5'b01000, 18));
    // flush in IDLE, flush beats ready commit, flush in HOLD
    tbl.push_back(mk(1,1,4,0,1, 5'b11000, 18));
    tbl.push_back(mk(1,1,1,0,0, 5'b11110, 18));
    tbl.push_back(mk(1,1,1,0,1, 5'b11001, 19));
    tbl.push_back(mk(1,1,1,0,0, 5'b11110, 19));
    tbl.push_back(mk(1,1,1,1,0, 5'b01100, 20));
    tbl.push_back(mk(1,1,1,1,1, 5'b01001, 21));
    tbl.push_back(mk(0,0,0,0,0, 5'b11000, 21));

    RST = 1'b0;
    drive(0,0,0,0,0);
    #12;
    chk("reset_state", 5'b01000, 0);
    @(posedge CLK); #1;
    RST = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].mc, tbl[i].lat, tbl[i].st, tbl[i].fl);
      #3;
      chk($sformatf("tbl[%0d]", i), tbl[i].o, tbl[i].cnt);
      @(posedge CLK); #1;
    end

    // randomized traffic
    inflight = 0;
    ready_at = 0;
    m_cnt    = tbl[tbl.size()-1].cnt;
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 99);
      v   = inflight ? 1'b1 : (sel < 75);
      mc  = ($urandom_range(0, 99) < 35);
      lat = $urandom_range(0, 15);
      st  = ($urandom_range(0, 99) < 30);
      fl  = ($urandom_range(0, 99) < 5);
      drive(v, mc, lat, st, fl);
      model(n, v, mc, lat, st, fl, exp_o);
      #3;
      chk($sformatf("rand[%0d]", n), exp_o, m_cnt);
      if (exp_o[2] && m_cnt < 65535) m_cnt++;
      @(posedge CLK); #1;
    end

    // async reset in the middle of a multi-cycle op
    drive(1,1,5,0,0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("rst_mid_exec", 5'b01000, 0);
    @(posedge CLK); #1;
    chk("rst_held", 5'b01000, 0);
    drive(1,0,0,0,0);
    #1;
    RST = 1'b1;
    #1;
    chk("post_rst_idle", 5'b10000, 0);
    @(posedge CLK); #1;
    chk("post_rst_next", 5'b10000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex2_stage_ctrl.md
# ex2_stage_ctrl

Sequencing controller for the pipe-3 EX2 stage. Generates the `ACT` strobe that commits the EX2 result set into the ME2 pipeline registers. Holds EX2 for multi-cycle operations and while ME2 is stalled, inserts bubbles, and aborts on flush. Sits beside the EX2 output unit; all EX2→ME2 register write enables derive from `ACT`.

## Interface
Parameters:
- `MC_MAX_LAT`, default 8: maximum extra cycles of a multi-cycle op; larger requests saturate to this value.
- `CNT_W`, default 4: latency counter width; must satisfy 2^CNT_W > MC_MAX_LAT.
- `STC_W`, default 16: width of the stall-cycle performance counter.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `r_ex2_valid_Q` in 1: EX2 holds a valid instruction.
- `ex2_mc` in 1: EX2 instruction is multi-cycle.
- `ex2_mc_lat` in CNT_W: extra cycles the multi-cycle op needs.
- `me2_stall` in 1: ME2 cannot accept this cycle.
- `flush` in 1: kill EX2 and all younger instructions.
- `ACT` out 1: commit EX2→ME2 registers this cycle.
- `BUBBLE` out 1: force ME2 valid to 0. Integration drives `r_me2_valid_D = r_ex2_valid_Q & ~BUBBLE`.
- `ex2_hold` out 1: upstream (EX1/ID) must not advance into EX2.
- `mc_start` out 1: one-cycle pulse that launches the multi-cycle unit.
- `mc_kill` out 1: one-cycle pulse that aborts the multi-cycle unit.
- `ex2_stall_cnt` out STC_W: saturating count of cycles with `ex2_hold`=1.

## Operation
- FSM states:
  - IDLE: no op in flight.
  - EXEC: multi-cycle op counting down.
  - HOLD: result ready, waiting for ME2.
- Effective latency: L = min(ex2_mc_lat, MC_MAX_LAT). `ex2_mc` with L=0 is treated as single-cycle.
- IDLE:
  - Not valid: `ACT`=~me2_stall, `BUBBLE`=1.
  - Valid single-cycle, `me2_stall`=0: `ACT`=1, `BUBBLE`=0.
  - Valid single-cycle, `me2_stall`=1: `ACT`=0, `ex2_hold`=1.
  - Valid multi-cycle with L>0: `mc_start`=1, cnt←L, go to EXEC. Also `ex2_hold`=1, `ACT`=~me2_stall, `BUBBLE`=1.
- EXEC:
  - `ex2_hold`=1 and cnt←cnt−1 each cycle.
  - While cnt>1: `ACT`=~me2_stall, `BUBBLE`=1.
  - When cnt==1, result is ready:
    - `me2_stall`=0: `ACT`=1, `BUBBLE`=0, `ex2_hold`=0, go to IDLE.
    - Otherwise go to HOLD.
- HOLD:
  - `ex2_hold`=1, `ACT`=0.
  - When `me2_stall`=0: `ACT`=1, `BUBBLE`=0, `ex2_hold`=0, go to IDLE.
- `flush` has the highest priority in any state:
  - Next state IDLE, cnt←0.
  - `ACT`=~me2_stall, `BUBBLE`=1, `ex2_hold`=0, `mc_start`=0.
  - `mc_kill`=1 if the current state is EXEC or HOLD.
  - ME2 contents are never flushed by this block.
- `ex2_stall_cnt` increments on every cycle with `ex2_hold`=1 and saturates at all-ones. Only reset clears it.
- `ex2_mc` and `ex2_mc_lat` are sampled only in IDLE. They are ignored in EXEC/HOLD.

## Timing
- Reset (RST=0, asynchronous): state=IDLE, cnt=0, `ex2_stall_cnt`=0. While reset is held, outputs are forced to `ACT`=0, `BUBBLE`=1, `ex2_hold`=0, `mc_start`=0, `mc_kill`=0.
- Reset deassertion mid-operation: the controller restarts in IDLE. No `mc_kill` is issued; the multi-cycle unit shares the same reset.
- `ACT`, `BUBBLE`, `ex2_hold`, `mc_start` and `mc_kill` are combinational from state and inputs. State and counters are registered.
- Single-cycle op: `ACT` is asserted in the same cycle as valid, provided ME2 is not stalled.
- Multi-cycle op with latency L: `mc_start` fires in cycle 0 and the commit happens in cycle L. The instruction occupies EX2 for L+1 cycles plus any ME2 stall cycles.
- `flush` together with `me2_stall`=0 while in EXEC with cnt==1: the flush wins, giving `BUBBLE`=1 and `mc_kill`=1.
- Upstream may load a new instruction into EX2 in the cycle after any cycle with `ex2_hold`=0.

## Structure
- Shared package `ex_ctrl_pkg`:
  - state encoding: IDLE=2'd0, EXEC=2'd1, HOLD=2'd2;
  - `MC_MAX_LAT` and `CNT_W` defaults.
- Sub-module `ex_sat_cnt`: parameterised saturating up-counter with enable and async active-low reset, used for `ex2_stall_cnt`.
- FSM and latency counter stay inline in `ex2_stage_ctrl`.

## Test plan
- Single-cycle stream: valid=1, ex2_mc=0, me2_stall=0 for 5 cycles → `ACT`=1 and `BUBBLE`=0 every cycle; `ex2_hold`=0; `ex2_stall_cnt`=0.
- Multi-cycle, L=3, no stall → `mc_start` in cycle 0; `ex2_hold`=1 in cycles 0–2; commit (`ACT`=1, `BUBBLE`=0) in cycle 3; `ex2_stall_cnt`=3.
- Multi-cycle, L=2, with me2_stall=1 in cycles 2–3 → state HOLD in cycle 3; commit in cycle 4; `ex2_stall_cnt`=4.
- Flush during EXEC (L=5, flush in cycle 2) → `mc_kill`=1 and `BUBBLE`=1 in cycle 2; IDLE in cycle 3; no commit with `BUBBLE`=0 for that instruction.
- Latency saturation and zero latency:
  - ex2_mc_lat=15 with MC_MAX_LAT=8 → commit in cycle 8;
  - ex2_mc=1 with ex2_mc_lat=0 → behaves as single-cycle, and `mc_start` stays 0.
- Async reset asserted mid-EXEC → outputs immediately at reset values; after release, state is IDLE and `ex2_stall_cnt`=0.
